// File: rtl/lut3_pkg.sv
// Shared truth-table constants and the lane index helper for the LUT3 pipeline.
package lut3_pkg;

  typedef logic [7:0] tt_t;

  localparam tt_t TT_DEMO = 8'h8F;
  localparam tt_t TT_AND3 = 8'h80;
  localparam tt_t TT_OR3  = 8'hFE;
  localparam tt_t TT_XOR3 = 8'h96;
  localparam tt_t TT_MAJ3 = 8'hE8;

  // Operand a is the most significant bit of the truth-table index.
  function automatic logic [2:0] lut3_idx(input logic a, input logic b, input logic c);
    return {a, b, c};
  endfunction

endpackage

// File: rtl/lut3_pipe_stage.sv
// One elastic pipeline slot: a valid flag plus a data word, loaded when enabled.
module lut3_pipe_stage #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/lut3_pipe.sv
// Runtime-programmable 3-input LUT applied per lane, carried through a
// bubble-collapsing valid/ready pipeline, with an output-change event counter.
module lut3_pipe
  import lut3_pkg::*;
#(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned LATENCY  = 2,
  parameter logic [7:0]  TT_RESET = 8'h8F,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [7:0]       cfg_tt,
  output logic [7:0]       tt_q,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  input  logic             chg_clr,
  output logic [CNT_W-1:0] chg_cnt
);

  logic [7:0]       tt_d;
  logic [WIDTH-1:0] eval_x;
  logic [LATENCY-1:0] v;
  logic [LATENCY-1:0] en;
  logic [WIDTH-1:0] d [LATENCY];

  logic             out_hs;
  logic [CNT_W-1:0] chg_cnt_q, chg_cnt_d;
  logic [WIDTH-1:0] last_x_q, last_x_d;

  // The table read here is the pre-edge value, so a beat accepted together
  // with cfg_we is evaluated with the old table.
  always_comb begin
    eval_x = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      eval_x[i] = tt_q[lut3_idx(in_a[i], in_b[i], in_c[i])];
    end
  end

  always_comb begin
    tt_d = cfg_we ? cfg_tt : tt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_q <= TT_RESET;
    end else begin
      tt_q <= tt_d;
    end
  end

  // A stage may load whenever it is empty or everything downstream can move.
  always_comb begin
    en = '0;
    en[LATENCY-1] = ~v[LATENCY-1] | out_ready;
    for (int unsigned k = 1; k < LATENCY; k++) begin
      en[LATENCY-1-k] = ~v[LATENCY-1-k] | en[LATENCY-k];
    end
  end

  assign in_ready = en[0];

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    logic             vin;
    logic [WIDTH-1:0] din;

    if (k == 0) begin : g_head
      assign vin = in_valid;
      assign din = eval_x;
    end else begin : g_body
      assign vin = v[k-1];
      assign din = d[k-1];
    end

    lut3_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en[k]),
      .valid_i (vin),
      .data_i  (din),
      .valid_o (v[k]),
      .data_o  (d[k])
    );
  end

  assign out_valid = v[LATENCY-1];
  assign out_x     = d[LATENCY-1];
  assign out_hs    = out_valid & out_ready;

  // Clear has priority over a coincident counted change; last_x tracks regardless.
  always_comb begin
    chg_cnt_d = chg_cnt_q;
    last_x_d  = last_x_q;
    if (out_hs) begin
      last_x_d = out_x;
      if ((out_x != last_x_q) && (chg_cnt_q != '1)) begin
        chg_cnt_d = chg_cnt_q + CNT_W'(1);
      end
    end
    if (chg_clr) begin
      chg_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_cnt_q <= '0;
      last_x_q  <= '0;
    end else begin
      chg_cnt_q <= chg_cnt_d;
      last_x_q  <= last_x_d;
    end
  end

  assign chg_cnt = chg_cnt_q;

endmodule

// File: tb/tb_lut3_pipe.sv
// Randomised and directed checks of lut3_pipe against a queue-based beat model.
module tb_lut3_pipe;
  import lut3_pkg::*;

  localparam int W  = 4;
  localparam int L  = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [7:0]    cfg_tt;
  logic [7:0]    tt_q;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a, in_b, in_c;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_x;
  logic          chg_clr;
  logic [CW-1:0] chg_cnt;

  lut3_pipe #(
    .WIDTH    (W),
    .LATENCY  (L),
    .TT_RESET (8'h8F),
    .CNT_W    (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_tt    (cfg_tt),
    .tt_q      (tt_q),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .chg_clr   (chg_clr),
    .chg_cnt   (chg_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each beat in flight remembers its result and which slot it occupies.
  typedef struct {
    logic [W-1:0] d;
    int           pos;
  } beat_t;

  beat_t         q[$];
  logic [W-1:0]  seen[$];
  logic [7:0]    m_tt;
  logic [CW-1:0] m_cnt;
  logic [W-1:0]  m_last;
  logic [W-1:0]  prev_x;
  bit            prev_stall;
  bit            last_acc;

  function automatic logic [W-1:0] ref_eval(input logic [7:0] tt, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [W-1:0] c);
    logic [W-1:0] r;
    int           idx;
    r = '0;
    for (int i = 0; i < W; i++) begin
      idx  = 4 * int'(a[i]) + 2 * int'(b[i]) + int'(c[i]);
      r[i] = tt[idx];
    end
    return r;
  endfunction

  // Called just after a rising edge; drives one cycle, checks at the falling
  // edge, then predicts what the next rising edge does.
  task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input logic ordy, input logic we,
                      input logic [7:0] tt, input logic clr);
    bit    exp_rdy, exp_ov;
    int    lim;
    beat_t nb;
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    in_c      = c;
    out_ready = ordy;
    cfg_we    = we;
    cfg_tt    = tt;
    chg_clr   = clr;
    @(negedge clk);
    exp_rdy = (q.size() < L) || ordy;
    exp_ov  = (q.size() > 0) && (q[0].pos == L - 1);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) chk("out_x", out_x, q[0].d);
    if (prev_stall) chk("out_x_hold", out_x, prev_x);
    chk("tt_q", tt_q, m_tt);
    chk("chg_cnt", chg_cnt, m_cnt);
    last_acc = iv && in_ready;
    if (out_valid && ordy) seen.push_back(out_x);
    if (exp_ov && ordy) begin
      if ((q[0].d !== m_last) && (m_cnt != '1)) m_cnt++;
      m_last = q[0].d;
      void'(q.pop_front());
    end
    if (clr) m_cnt = '0;
    for (int i = 0; i < q.size(); i++) begin
      lim = (i == 0) ? L - 1 : q[i-1].pos - 1;
      q[i].pos = (q[i].pos + 1 < lim) ? q[i].pos + 1 : lim;
    end
    if (exp_rdy && iv) begin
      nb.d   = ref_eval(m_tt, a, b, c);
      nb.pos = 0;
      q.push_back(nb);
    end
    if (we) m_tt = tt;
    prev_stall = exp_ov && !ordy;
    prev_x     = out_x;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_x", out_x, '0);
    q.delete();
    m_tt       = 8'h8F;
    m_cnt      = '0;
    m_last     = '0;
    prev_stall = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    cfg_we     = 1'b0;
    chg_clr    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] bp_a[5], bp_b[5], bp_c[5];
  int           idx;

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0;
    out_ready = 1'b1; cfg_we = 1'b0; cfg_tt = '0; chg_clr = 1'b0;
    #2;
    apply_reset();

    chk("reset_tt", tt_q, 8'h8F);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_chg_cnt", chg_cnt, '0);

    // Demo vectors, every lane identical
    seen.delete();
    step(1'b1, 4'hF, 4'h0, 4'hF, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0);
    idle(5);
    chk("demo_count", seen.size(), 4);
    if (seen.size() == 4) begin
      chk("demo_x0", seen[0], 4'h0);
      chk("demo_x1", seen[1], 4'h0);
      chk("demo_x2", seen[2], 4'hF);
      chk("demo_x3", seen[3], 4'hF);
    end
    chk("demo_chg_cnt", chg_cnt, 4'd1);

    // Backpressure: only L beats fit while out_ready is low
    seen.delete();
    for (int i = 0; i < 5; i++) begin
      bp_a[i] = W'($urandom); bp_b[i] = W'($urandom); bp_c[i] = W'($urandom);
    end
    idx = 0;
    for (int t = 0; t < 5; t++) begin
      step(1'b1, bp_a[idx], bp_b[idx], bp_c[idx], 1'b0, 1'b0, 8'h00, 1'b0);
      if (last_acc) idx++;
    end
    chk("bp_accepted", idx, L);
    chk("bp_in_ready", in_ready, 1'b0);
    for (int t = 0; t < 30 && (idx < 5 || q.size() > 0); t++) begin
      step(idx < 5, bp_a[idx % 5], bp_b[idx % 5], bp_c[idx % 5], 1'b1, 1'b0, 8'h00, 1'b0);
      if (last_acc) idx++;
    end
    chk("bp_drained", q.size(), 0);
    chk("bp_count", seen.size(), 5);

    // Table write on the accepting edge
    seen.delete();
    step(1'b1, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1, TT_XOR3, 1'b0);
    step(1'b1, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0);
    idle(5);
    chk("cfg_count", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("cfg_old_table", seen[0], 4'h0);
      chk("cfg_new_table", seen[1], 4'hF);
    end
    chk("cfg_tt", tt_q, TT_XOR3);

    // Counter saturation with XOR table: out_x follows a
    for (int k = 0; k < 20; k++) begin
      step(1'b1, (k % 2 == 1) ? 4'hF : 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0);
    end
    idle(5);
    chk("cnt_saturated", chg_cnt, 4'hF);

    step(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int t = 0; t < 10 && !out_valid; t++) step(1'b0, '0, '0, '0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("clr_wait_valid", out_valid, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("clr_wins", chg_cnt, '0);
    step(1'b1, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0);
    idle(5);
    chk("cnt_after_clr", chg_cnt, 4'd1);

    // Randomised traffic with occasional table writes and clears
    for (int t = 0; t < 400; t++) begin
      step(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), W'($urandom),
           1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 15) == 0), 8'($urandom),
           1'($urandom_range(0, 31) == 0));
    end
    for (int t = 0; t < 20 && q.size() > 0; t++) idle(1);
    chk("rand_drained", q.size(), 0);

    // Reset with beats in flight
    step(1'b1, 4'hA, 4'h5, 4'h3, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 4'h5, 4'hA, 4'hC, 1'b0, 1'b0, 8'h00, 1'b0);
    #2;
    apply_reset();
    seen.delete();
    idle(6);
    chk("rst_no_stale", seen.size(), 0);
    step(1'b1, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 8'h00, 1'b0);
    idle(5);
    chk("rst_recover_count", seen.size(), 1);
    if (seen.size() == 1) chk("rst_recover_x", seen[0], 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lut3_pipe.md
Name: lut3_pipe

Overview:
- Parametrised, clocked successor to the team's fixed 3-input gate cell (x = ~a | (b & c)).
- Applies a runtime-loadable 3-input truth table bitwise across WIDTH lanes.
- Carries results through a LATENCY-deep elastic valid/ready pipeline.
- Counts output-change events for on-chip monitoring in place of bench-side $monitor.

Parameters:
- WIDTH, 1: number of independent bit lanes.
- LATENCY, 2: pipeline register stages, accept to out_valid; legal range 1..8.
- TT_RESET, 8'h8F: truth table loaded at reset, equal to ~a | (b & c).
- CNT_W, 16: width of the change counter.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  truth-table write strobe
- cfg_tt  in  8  new truth table
- tt_q  out  8  current truth table
- in_valid  in  1  input beat valid
- in_ready  out  1  pipeline can accept
- in_a  in  WIDTH  operand a, per lane
- in_b  in  WIDTH  operand b, per lane
- in_c  in  WIDTH  operand c, per lane
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_x  out  WIDTH  result, per lane
- chg_clr  in  1  synchronous clear of chg_cnt
- chg_cnt  out  CNT_W  count of output handshakes whose data differed from the previous one

Behaviour:
- Reset (async assert, sync release):
  - all stage valids = 0, stage data = 0;
  - out_valid = 0, out_x = 0;
  - tt_q = TT_RESET, chg_cnt = 0, last_x = 0;
  - in_ready = 1 as soon as rst_n is high.
- Reset mid-operation: in-flight beats are discarded, not completed.
- Evaluation:
  - Lane i result = tt_q[{a[i], b[i], c[i]}], with a as MSB.
  - Computed at the accepting edge into stage 0.
  - Stages 1..LATENCY-1 carry data unchanged.
- Handshake:
  - A beat is accepted on an edge with in_valid & in_ready.
  - A beat leaves on an edge with out_valid & out_ready.
  - out_x is held stable while out_valid & ~out_ready.
- Bubble-collapsing pipeline, stage k = 0..LATENCY-1:
  - en[LATENCY-1] = ~v[LATENCY-1] | out_ready.
  - en[k] = ~v[k] | en[k+1].
  - in_ready = en[0].
  - When en[k] is set, stage k loads from stage k-1 (stage 0 loads from the input), and v[k] takes the upstream valid.
  - Ready is combinational; no path from in_valid to in_ready.
- Latency and throughput:
  - With no stalls, a beat accepted at edge N gives out_valid after edge N+LATENCY-1, i.e. visible in cycle N+LATENCY.
  - Throughput is 1 beat/cycle.
  - Full stall: LATENCY beats are held and in_ready = 0.
- Config:
  - cfg_we loads tt_q at the edge.
  - A beat accepted on the same edge uses the old table; beats accepted later use the new one.
  - Beats already in flight are never re-evaluated.
- Change counter:
  - On each output handshake, if out_x != last_x, chg_cnt increments; it saturates at all-ones with no wrap.
  - last_x <= out_x on every output handshake.
  - The first beat after reset is compared against 0.
- chg_clr:
  - chg_cnt = 0 on the next edge.
  - If chg_clr coincides with a counted change, the clear wins (result 0); last_x still updates.

Decomposition:
- Package lut3_pkg:
  - Truth-table constants TT_DEMO = 8'h8F, TT_AND3 = 8'h80, TT_OR3 = 8'hFE, TT_XOR3 = 8'h96, TT_MAJ3 = 8'hE8.
  - Function lut3_idx(a, b, c) returning the 3-bit index.
- Sub-module lut3_pipe_stage:
  - One valid+data register with its enable input.
  - Instantiated LATENCY times in a generate loop.
- The top level holds the evaluation logic, tt_q, the ready chain and the counter.

Test Plan:
- Reset-value check, WIDTH=1, LATENCY=2, out_ready=1: after reset release, tt_q = 8'h8F, out_valid = 0, in_ready = 1, chg_cnt = 0.
- Demo vector sequence, one beat per cycle, out_ready=1: (a,b,c) = (1,0,1), (1,0,0), (1,1,1), (0,0,0) gives out_x = 0, 0, 1, 1. Each appears 2 cycles after acceptance; chg_cnt = 1 at the end.
- Backpressure, LATENCY=3: hold out_ready = 0 and offer 5 beats. Exactly 3 are accepted, then in_ready = 0 and out_x is stable. Release: remaining beats drain in order with no loss or duplication.
- Config timing, WIDTH=4: write TT_XOR3 on the same edge as accepting a=4'hF, b=0, c=0 → out_x = 4'h0 (old table, idx4 → 0). The next beat with the same inputs → 4'hF.
- Counter limits, CNT_W=4: alternate out_x 20 times → chg_cnt saturates at 4'hF. Assert chg_clr together with a change → chg_cnt = 0, and the next differing beat → 1.
- Async reset mid-stream: drop rst_n with 2 beats in flight → out_valid = 0 immediately and no stale beat emerges after release.
